xylo_sequenciador: RTL and testbench

XYLO_SEQUENCIADOR -- requirements
Module: xylo_sequenciador

---
 rtl/xylo_sequenciador.sv | 170 +++++++++++++++++
 tb/tb_xylo_sequenciador.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/xylo_sequenciador.sv
// Melody sequencer: plays a 16-entry note table onto the xylophone datapath.
// Latency: iniciar seen at one clock edge -> tocando observed high at the second edge after it.
// Flow control: none; parar aborts at once, and iniciar/escrever are ignored unless idle.
//
// Ports:
//   clock, reset          single rising-edge clock, synchronous active-high reset
//   iniciar, parar        start / abort playback (parar wins when both are high)
//   escrever, endereco,   melody table write port, accepted only while idle;
//   dado                  dado = {ultimo, tom, notas[2:0], duracao[3:0]}
//   Tom, Notas            note select towards the xylophone datapath
//   tocando               Tom/Notas are a sounding note
//   ocupado               sequencer is not idle
//   fim                   one-cycle pulse on normal completion of the melody
//   indice                table address of the entry being loaded/played
module xylo_sequenciador #(
   parameter int TICKS_POR_UNIDADE = 4,
   parameter int COMPRIMENTO       = 16
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       iniciar,
   input  logic       parar,
   input  logic       escrever,
   input  logic [3:0] endereco,
   input  logic [8:0] dado,
   output logic       Tom,
   output logic [2:0] Notas,
   output logic       tocando,
   output logic       ocupado,
   output logic       fim,
   output logic [3:0] indice
);

   // Wide enough for 15 units of TICKS_POR_UNIDADE cycles each.
   localparam int            CW         = 4 + $clog2(TICKS_POR_UNIDADE) + 1;
   localparam logic [CW-1:0] TICKS_W    = CW'(TICKS_POR_UNIDADE);
   localparam logic [3:0]    ULTIMO_IDX = 4'(COMPRIMENTO - 1);

   typedef enum logic [2:0] {
      OCIOSO  = 3'd0,
      CARREGA = 3'd1,
      TOCA    = 3'd2,
      PAUSA   = 3'd3,
      FIM     = 3'd4
   } estado_t;

   estado_t       estado_q, estado_d;
   logic [8:0]    mem_q [COMPRIMENTO];
   logic [8:0]    mem_d [COMPRIMENTO];
   logic [CW-1:0] contador_q, contador_d;
   logic          ultimo_q, ultimo_d;
   logic          tom_q, tom_d;
   logic [2:0]    notas_q, notas_d;
   logic          tocando_q, tocando_d;
   logic          ocupado_q, ocupado_d;
   logic          fim_q, fim_d;
   logic [3:0]    indice_q, indice_d;
   logic [8:0]    entrada;

   always_comb begin
      estado_d   = estado_q;
      mem_d      = mem_q;
      contador_d = contador_q;
      ultimo_d   = ultimo_q;
      tom_d      = tom_q;
      notas_d    = notas_q;
      tocando_d  = tocando_q;
      fim_d      = 1'b0;
      indice_d   = indice_q;
      entrada    = mem_q[indice_q];

      // The table is only writable while idle, so a write that coincides with
      // iniciar lands before CARREGA reads it on the following cycle.
      if (estado_q == OCIOSO && escrever) begin
         mem_d[endereco] = dado;
      end

      if (parar) begin
         // Abort: everything else holds, the note goes silent, no fim pulse.
         estado_d  = OCIOSO;
         tocando_d = 1'b0;
      end else begin
         case (estado_q)
            OCIOSO: begin
               if (iniciar) begin
                  indice_d = 4'd0;
                  estado_d = CARREGA;
               end
            end
            CARREGA: begin
               tom_d    = entrada[7];
               notas_d  = entrada[6:4];
               ultimo_d = entrada[8];
               // A zero duration is a rest lasting one unit.
               if (entrada[3:0] == 4'd0) begin
                  contador_d = TICKS_W;
                  tocando_d  = 1'b0;
               end else begin
                  contador_d = CW'(entrada[3:0]) * TICKS_W;
                  tocando_d  = 1'b1;
               end
               estado_d = TOCA;
            end
            TOCA: begin
               // Counter holds the cycles left including the current one.
               if (contador_q <= CW'(1)) begin
                  tocando_d = 1'b0;
                  estado_d  = PAUSA;
               end else begin
                  contador_d = contador_q - CW'(1);
               end
            end
            PAUSA: begin
               if (ultimo_q || indice_q == ULTIMO_IDX) begin
                  fim_d    = 1'b1;
                  estado_d = FIM;
               end else begin
                  indice_d = indice_q + 4'd1;
                  estado_d = CARREGA;
               end
            end
            FIM: begin
               estado_d = OCIOSO;
            end
            default: begin
               estado_d  = OCIOSO;
               tocando_d = 1'b0;
            end
         endcase
      end

      ocupado_d = (estado_d != OCIOSO);
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         estado_q   <= OCIOSO;
         for (int i = 0; i < COMPRIMENTO; i++) begin
            mem_q[i] <= 9'd0;
         end
         contador_q <= '0;
         ultimo_q   <= 1'b0;
         tom_q      <= 1'b0;
         notas_q    <= 3'd0;
         tocando_q  <= 1'b0;
         ocupado_q  <= 1'b0;
         fim_q      <= 1'b0;
         indice_q   <= 4'd0;
      end else begin
         estado_q   <= estado_d;
         mem_q      <= mem_d;
         contador_q <= contador_d;
         ultimo_q   <= ultimo_d;
         tom_q      <= tom_d;
         notas_q    <= notas_d;
         tocando_q  <= tocando_d;
         ocupado_q  <= ocupado_d;
         fim_q      <= fim_d;
         indice_q   <= indice_d;
      end
   end

   assign Tom     = tom_q;
   assign Notas   = notas_q;
   assign tocando = tocando_q;
   assign ocupado = ocupado_q;
   assign fim     = fim_q;
   assign indice  = indice_q;

endmodule

// File: tb/tb_xylo_sequenciador.sv
// Bench for xylo_sequenciador with TICKS_POR_UNIDADE=2.
// A reference model expands the melody table into the expected per-cycle trace.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_xylo_sequenciador;

   localparam int T = 2;

   logic       clock;
   logic       reset;
   logic       iniciar;
   logic       parar;
   logic       escrever;
   logic [3:0] endereco;
   logic [8:0] dado;
   logic       Tom;
   logic [2:0] Notas;
   logic       tocando;
   logic       ocupado;
   logic       fim;
   logic [3:0] indice;

   xylo_sequenciador #(
      .TICKS_POR_UNIDADE(T),
      .COMPRIMENTO(16)
   ) dut (
      .clock(clock),
      .reset(reset),
      .iniciar(iniciar),
      .parar(parar),
      .escrever(escrever),
      .endereco(endereco),
      .dado(dado),
      .Tom(Tom),
      .Notas(Notas),
      .tocando(tocando),
      .ocupado(ocupado),
      .fim(fim),
      .indice(indice)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // One expected cycle of outputs; importa marks cycles where Tom/Notas are defined.
   typedef struct {
      logic       tom;
      logic [2:0] notas;
      logic       tocando;
      logic       ocupado;
      logic       fim;
      logic [3:0] indice;
      logic       importa;
   } passo_t;

   passo_t     esperado[$];
   logic [8:0] ref_mem [16];
   int         total = 0;
   int         bad   = 0;

   task automatic conferir(input string tag, input logic [31:0] obs, input logic [31:0] esp);
      total++;
      if (obs !== esp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, esp, $time);
      end
   endtask

   function automatic passo_t mk(input logic tom, input logic [2:0] notas, input logic toc,
                                 input logic ocu, input logic f, input logic [3:0] idx,
                                 input logic imp);
      passo_t r;
      r.tom     = tom;
      r.notas   = notas;
      r.tocando = toc;
      r.ocupado = ocu;
      r.fim     = f;
      r.indice  = idx;
      r.importa = imp;
      return r;
   endfunction

   // Expected trace from the first cycle after iniciar is taken: per entry one
   // load cycle, the note (or rest) for its duration, one pause; then fim and idle.
   function automatic void montar();
      logic [8:0] e;
      int         len;
      esperado.delete();
      for (int idx = 0; idx < 16; idx++) begin
         e   = ref_mem[idx];
         len = (e[3:0] == 4'd0) ? T : int'(e[3:0]) * T;
         esperado.push_back(mk(1'b0, 3'd0, 1'b0, 1'b1, 1'b0, 4'(idx), 1'b0));
         for (int c = 0; c < len; c++)
            esperado.push_back(mk(e[7], e[6:4], e[3:0] != 4'd0, 1'b1, 1'b0, 4'(idx), 1'b1));
         esperado.push_back(mk(e[7], e[6:4], 1'b0, 1'b1, 1'b0, 4'(idx), 1'b1));
         if (e[8] || idx == 15) begin
            esperado.push_back(mk(1'b0, 3'd0, 1'b0, 1'b1, 1'b1, 4'(idx), 1'b0));
            esperado.push_back(mk(1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 4'(idx), 1'b0));
            break;
         end
      end
   endfunction

   task automatic limpa_entradas();
      iniciar  = 1'b0;
      parar    = 1'b0;
      escrever = 1'b0;
      reset    = 1'b0;
   endtask

   task automatic aplica_reset();
      @(negedge clock);
      reset    = 1'b1;
      iniciar  = 1'b1;
      escrever = 1'b1;
      endereco = 4'd3;
      dado     = 9'h1ff;
      @(negedge clock);
      limpa_entradas();
      for (int i = 0; i < 16; i++) ref_mem[i] = 9'd0;
      conferir("rst_tom",     32'(Tom),     32'd0);
      conferir("rst_notas",   32'(Notas),   32'd0);
      conferir("rst_tocando", 32'(tocando), 32'd0);
      conferir("rst_ocupado", 32'(ocupado), 32'd0);
      conferir("rst_fim",     32'(fim),     32'd0);
      conferir("rst_indice",  32'(indice),  32'd0);
   endtask

   task automatic escreve(input logic [3:0] a, input logic [8:0] v);
      @(negedge clock);
      escrever = 1'b1;
      endereco = a;
      dado     = v;
      ref_mem[a] = v;
      @(negedge clock);
      escrever = 1'b0;
   endtask

   // modo: 0 plays to completion, 1 aborts with parar, 2 aborts with reset,
   // at trace position abort_em. lixo drives random iniciar/escrever while busy.
   task automatic tocar(input int modo, input int abort_em, input bit lixo,
                        input bit com_escrita, input logic [3:0] w_end, input logic [8:0] w_dado);
      passo_t p;
      @(negedge clock);
      limpa_entradas();
      iniciar = 1'b1;
      if (com_escrita) begin
         escrever   = 1'b1;
         endereco   = w_end;
         dado       = w_dado;
         ref_mem[w_end] = w_dado;
      end
      montar();
      for (int k = 0; k < esperado.size(); k++) begin
         @(negedge clock);
         limpa_entradas();
         p = esperado[k];
         conferir($sformatf("ctrl[%0d]", k), 32'({tocando, ocupado, fim}),
                  32'({p.tocando, p.ocupado, p.fim}));
         if (p.ocupado)
            conferir($sformatf("indice[%0d]", k), 32'(indice), 32'(p.indice));
         if (p.importa)
            conferir($sformatf("nota[%0d]", k), 32'({Tom, Notas}), 32'({p.tom, p.notas}));
         if (p.ocupado && k == abort_em && modo != 0) begin
            iniciar  = 1'b1;
            escrever = 1'b1;
            endereco = 4'($urandom);
            dado     = 9'($urandom);
            if (modo == 1) parar = 1'b1;
            else reset = 1'b1;
            @(negedge clock);
            limpa_entradas();
            conferir("abort_ctrl", 32'({tocando, ocupado, fim}), 32'd0);
            if (modo == 2) begin
               conferir("abort_rst_saidas", 32'({Tom, Notas, indice}), 32'd0);
               for (int i = 0; i < 16; i++) ref_mem[i] = 9'd0;
            end
            @(negedge clock);
            conferir("abort_sem_fim", 32'({ocupado, fim}), 32'd0);
            return;
         end
         if (lixo && p.ocupado) begin
            iniciar  = 1'($urandom);
            escrever = 1'($urandom);
            endereco = 4'($urandom);
            dado     = 9'($urandom);
         end
      end
   endtask

   initial begin
      logic [8:0] v;
      reset    = 1'b0;
      iniciar  = 1'b0;
      parar    = 1'b0;
      escrever = 1'b0;
      endereco = 4'd0;
      dado     = 9'd0;

      aplica_reset();

      // Two-note melody, second entry flagged as last.
      escreve(4'd0, 9'b0_1_101_0011);
      escreve(4'd1, 9'b1_0_010_0001);
      tocar(0, -1, 1'b0, 1'b0, 4'd0, 9'd0);

      // parar together with iniciar while idle keeps the sequencer idle.
      @(negedge clock);
      iniciar = 1'b1;
      parar   = 1'b1;
      @(negedge clock);
      limpa_entradas();
      conferir("parar_vence", 32'({ocupado, tocando}), 32'd0);
      @(negedge clock);
      conferir("parar_vence_2", 32'({ocupado, fim}), 32'd0);

      // Single rest entry marked last.
      escreve(4'd0, 9'b1_1_011_0000);
      tocar(0, -1, 1'b0, 1'b0, 4'd0, 9'd0);

      // Full table of one-unit notes: indice must reach 15 and stop there.
      for (int i = 0; i < 16; i++) begin
         v = 9'($urandom);
         v[8] = 1'b0;
         v[3:0] = 4'd1;
         escreve(4'(i), v);
      end
      tocar(0, -1, 1'b1, 1'b0, 4'd0, 9'd0);

      // Abort with parar mid-note amid ignored writes, then replay the same table.
      escreve(4'd0, 9'b1_1_110_0101);
      tocar(1, 4, 1'b1, 1'b0, 4'd0, 9'd0);
      tocar(0, -1, 1'b1, 1'b0, 4'd0, 9'd0);

      // Write on the same cycle as iniciar is seen by the load.
      tocar(0, -1, 1'b0, 1'b1, 4'd0, 9'b1_0_001_0010);

      // Randomised tables, occasional parar aborts, random write-with-start.
      for (int it = 0; it < 14; it++) begin
         for (int i = 0; i < 16; i++) begin
            if ($urandom_range(0, 1) == 1) begin
               v = 9'($urandom);
               v[3:0] = 4'($urandom_range(0, 3));
               v[8] = ($urandom_range(0, 4) == 0);
               escreve(4'(i), v);
            end
         end
         v = 9'($urandom);
         v[3:0] = 4'($urandom_range(0, 3));
         tocar(($urandom_range(0, 3) == 0) ? 1 : 0, $urandom_range(0, 30), 1'b1,
               1'($urandom), 4'($urandom), v);
      end

      // Reset mid-playback with iniciar high, then the cleared table plays silent rests.
      escreve(4'd0, 9'b1_1_111_0100);
      tocar(2, 3, 1'b0, 1'b0, 4'd0, 9'd0);
      tocar(0, -1, 1'b0, 1'b0, 4'd0, 9'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
